// File: rtl/kalman_fx_pkg.sv
// Shared fixed-point helpers and state encoding for the Kalman gain divider.
package kalman_fx_pkg;

  // Number of sign bits in every signed fixed-point format used here
  localparam int SIGN = 1;

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} k_div_state_t;

  // Fractional bit count of an S.ibits.frac format of total width dw
  function automatic int flt(input int dw, input int ibits);
    return dw - ibits - SIGN;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Largest positive two's complement value of width w (low w bits valid)
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's complement value of width w (low w bits valid)
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/k_gain_div_if.sv
// Operand/result handshake bundle for the Kalman gain divider.
interface k_gain_div_if #(
  parameter int DW_N = 24,
  parameter int DW_D = 24,
  parameter int DW_Q = 24
) ();
  logic            in_valid;
  logic            in_ready;
  logic [DW_N-1:0] num;
  logic [DW_D-1:0] den;
  logic            out_valid;
  logic            out_ready;
  logic [DW_Q-1:0] quot;
  logic            ovf;
  logic            dz;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, num, den, out_ready,
    input  in_ready, out_valid, quot, ovf, dz
  );

  // The divider itself
  modport slave (
    input  in_valid, num, den, out_ready,
    output in_ready, out_valid, quot, ovf, dz
  );
endinterface

// File: rtl/k_gain_div_sat.sv
// Sign restore and saturation of the unsigned quotient magnitude.
module k_gain_div_sat
  import kalman_fx_pkg::*;
#(
  parameter int DW_Q = 24
) (
  input  logic [DW_Q-1:0] q,
  input  logic            sign,
  input  logic            ovf,
  input  logic            dz,
  input  logic            num_zero,
  output logic [DW_Q-1:0] quot
);

  localparam logic [DW_Q-1:0] Q_MAX = DW_Q'(sat_max(DW_Q));
  localparam logic [DW_Q-1:0] Q_MIN = DW_Q'(sat_min(DW_Q));

  // Saturate toward the result sign on overflow/divide-by-zero; 0/0 goes positive
  always_comb begin
    quot = q;
    if (ovf || dz) begin
      quot = (sign && !num_zero) ? Q_MIN : Q_MAX;
    end else if (sign) begin
      quot = ~q + DW_Q'(1);
    end
  end

endmodule

// File: rtl/k_gain_div.sv
// Sequential signed fixed-point divider K = num / den, radix-2 restoring,
// one quotient bit per clock. Optional rounding: define K_GAIN_DIV_ROUND_EN.
module k_gain_div
  import kalman_fx_pkg::*;
#(
  parameter int DW_N  = 24,
  parameter int INT_N = 0,
  parameter int DW_D  = 24,
  parameter int DW_Q  = 24,
  parameter int INT_Q = 2
) (
  input logic           clk,
  input logic           rst,
  k_gain_div_if.slave   bus
);

  localparam int FLT_N   = flt(DW_N, INT_N);
  localparam int FLT_D   = flt(DW_D, 0);
  localparam int FLT_Q   = flt(DW_Q, INT_Q);
  localparam int SHIFT   = FLT_Q + FLT_D - FLT_N;
  localparam int SHIFT_C = (SHIFT < 0) ? 0 : SHIFT;
`ifdef K_GAIN_DIV_ROUND_EN
  localparam int ROUND_EN = 1;
`else
  localparam int ROUND_EN = 0;
`endif
  localparam int N_ITER = DW_Q - 1 + ROUND_EN;
  localparam int RW     = DW_N + SHIFT_C;
  // Wide enough for |den|<<(DW_Q-1) and for 2*rem in the rounding step
  localparam int CW     = imax(RW + 1, DW_D + DW_Q);
  localparam int CNT_W  = $clog2(N_ITER + 1);

  if (SHIFT < 0) begin : g_shift_chk
    $error("k_gain_div: quotient/denominator fraction bits too small for numerator format");
  end

  k_div_state_t state_reg, state_next;

  logic [DW_N-1:0]  num_reg;
  logic [DW_D-1:0]  den_reg;
  logic             sign_reg;
  logic             num_zero_reg;
  logic             dz_reg;
  logic             ovf_reg;
  logic [RW-1:0]    rem_reg;
  logic [CW-1:0]    dvs_reg;
  logic [DW_Q-2:0]  q_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [DW_Q-1:0]  quot_reg;
  logic             ovf_out_reg;
  logic             dz_out_reg;
  logic             in_ready_c;
  logic             out_valid_c;

  logic [DW_N-1:0]  num_mag;
  logic [DW_D-1:0]  den_mag;
  logic [CW-1:0]    num_wide;
  logic [CW-1:0]    den_top;
  logic             take;
  logic [RW-1:0]    rem_diff;
  logic             round_step;
  logic             round_bit;
  logic [DW_Q-1:0]  q_sum;
  logic             ovf_fix;
  logic [DW_Q-1:0]  quot_fix;

`ifdef K_GAIN_DIV_ROUND_EN
  logic [DW_D-1:0]  den_mag_reg;
  logic             round_reg;
  logic             half_ge;
  assign half_ge    = CW'({rem_reg, 1'b0}) >= CW'(den_mag_reg);
  assign round_step = (cnt_reg == CNT_W'(DW_Q - 1));
  assign round_bit  = round_reg;
`else
  assign round_step = 1'b0;
  assign round_bit  = 1'b0;
`endif

  // Magnitudes as unsigned; the most negative input maps to 2^(DW-1)
  assign num_mag  = num_reg[DW_N-1] ? (~num_reg + DW_N'(1)) : num_reg;
  assign den_mag  = den_reg[DW_D-1] ? (~den_reg + DW_D'(1)) : den_reg;
  assign num_wide = CW'(num_mag) << SHIFT_C;
  assign den_top  = CW'(den_mag) << (DW_Q - 1);

  // One trial subtraction of the current shifted divisor per iteration
  assign take     = CW'(rem_reg) >= dvs_reg;
  assign rem_diff = rem_reg - dvs_reg[RW-1:0];

  // A rounding carry into the sign position is an overflow as well
  assign q_sum    = {1'b0, q_reg} + DW_Q'(round_bit);
  assign ovf_fix  = ovf_reg | q_sum[DW_Q-1];

  k_gain_div_sat #(.DW_Q(DW_Q)) u_sat (
    .q        (q_sum),
    .sign     (sign_reg),
    .ovf      (ovf_fix),
    .dz       (dz_reg),
    .num_zero (num_zero_reg),
    .quot     (quot_fix)
  );

  // State register; reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = LOAD;
      end
      LOAD: state_next = ITER;
      ITER: if (cnt_reg == CNT_W'(N_ITER - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture, setup, iterate, then register the final result
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      quot_reg    <= '0;
      ovf_out_reg <= 1'b0;
      dz_out_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            num_reg <= bus.num;
            den_reg <= bus.den;
          end
        end
        LOAD: begin
          sign_reg     <= num_reg[DW_N-1] ^ den_reg[DW_D-1];
          num_zero_reg <= (num_reg == '0);
          dz_reg       <= (den_reg == '0);
          ovf_reg      <= (den_reg != '0) && (num_wide >= den_top);
          rem_reg      <= RW'(num_mag) << SHIFT_C;
          dvs_reg      <= CW'(den_mag) << (DW_Q - 2);
          q_reg        <= '0;
          cnt_reg      <= '0;
`ifdef K_GAIN_DIV_ROUND_EN
          den_mag_reg  <= den_mag;
          round_reg    <= 1'b0;
`endif
        end
        ITER: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (!round_step) begin
            if (take) rem_reg <= rem_diff;
            q_reg   <= {q_reg[DW_Q-3:0], take};
            dvs_reg <= dvs_reg >> 1;
          end
`ifdef K_GAIN_DIV_ROUND_EN
          if (round_step) round_reg <= half_ge;
`endif
        end
        FIX: begin
          quot_reg    <= quot_fix;
          ovf_out_reg <= ovf_fix;
          dz_out_reg  <= dz_reg;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.quot      = quot_reg;
  assign bus.ovf       = ovf_out_reg;
  assign bus.dz        = dz_out_reg;

endmodule

// File: tb/tb_k_gain_div.sv
// Directed self-checking bench for k_gain_div (default 24-bit formats).
module tb_k_gain_div;

`ifdef K_GAIN_DIV_ROUND_EN
  localparam int EXP_LAT = 26;
  localparam logic [23:0] Q_THIRD  = 24'h0AAAAB;
  localparam logic [23:0] Q_NTHIRD = 24'hF55555;
`else
  localparam int EXP_LAT = 25;
  localparam logic [23:0] Q_THIRD  = 24'h0AAAAA;
  localparam logic [23:0] Q_NTHIRD = 24'hF55556;
`endif

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  k_gain_div_if #(.DW_N(24), .DW_D(24), .DW_Q(24)) bus_if ();

  k_gain_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One job: offer operands, time the result, check it, optionally stall the output
  task automatic run_job(input string tag, input logic [23:0] n, input logic [23:0] d,
                         input logic [23:0] eq, input logic eo, input logic ez, input int hold);
    int   lat;
    logic got;
    logic [23:0] q_seen;
    @(negedge clk);
    chk({tag, " in_ready_idle"}, {31'b0, bus_if.in_ready}, 32'd1);
    bus_if.in_valid  = 1'b1;
    bus_if.num       = n;
    bus_if.den       = d;
    bus_if.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      got = bus_if.out_valid;
    end
    chk({tag, " out_valid_seen"}, {31'b0, got}, 32'd1);
    chk({tag, " latency"}, lat, EXP_LAT);
    chk({tag, " quot"}, {8'b0, bus_if.quot}, {8'b0, eq});
    chk({tag, " ovf"}, {31'b0, bus_if.ovf}, {31'b0, eo});
    chk({tag, " dz"}, {31'b0, bus_if.dz}, {31'b0, ez});
    q_seen = bus_if.quot;
    if (hold > 0) begin
      bus_if.in_valid = 1'b1;
      bus_if.num      = ~n;
      bus_if.den      = 24'h000001;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, " hold_valid"}, {31'b0, bus_if.out_valid}, 32'd1);
        chk({tag, " hold_in_ready"}, {31'b0, bus_if.in_ready}, 32'd0);
        chk({tag, " hold_quot"}, {8'b0, bus_if.quot}, {8'b0, eq});
        chk({tag, " hold_flags"}, {30'b0, bus_if.ovf, bus_if.dz}, {30'b0, eo, ez});
      end
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({tag, " release_valid"}, {31'b0, bus_if.out_valid}, 32'd0);
    chk({tag, " release_in_ready"}, {31'b0, bus_if.in_ready}, 32'd1);
    $display("job %s num=0x%06h den=0x%06h quot=0x%06h ovf=%0b dz=%0b latency=%0d",
             tag, n, d, q_seen, eo, ez, lat);
  endtask

  initial begin
    int seen;
    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.num       = '0;
    bus_if.den       = '0;
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", {31'b0, bus_if.in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    chk("reset quot", {8'b0, bus_if.quot}, 32'd0);
    chk("reset flags", {30'b0, bus_if.ovf, bus_if.dz}, 32'd0);

    run_job("quarter_over_half", 24'h200000, 24'h400000, 24'h100000, 1'b0, 1'b0, 0);
    run_job("neg_div_pos",       24'hD00000, 24'h100000, 24'hA00000, 1'b0, 1'b0, 0);
    run_job("ovf_pos",           24'h600000, 24'h100000, 24'h7FFFFF, 1'b1, 1'b0, 0);
    run_job("ovf_neg_exact",     24'hC00000, 24'h100000, 24'h800000, 1'b1, 1'b0, 0);
    run_job("dz_pos",            24'h100000, 24'h000000, 24'h7FFFFF, 1'b0, 1'b1, 0);
    run_job("dz_neg",            24'hF00000, 24'h000000, 24'h800000, 1'b0, 1'b1, 0);
    run_job("dz_zero",           24'h000000, 24'h000000, 24'h7FFFFF, 1'b0, 1'b1, 0);
    run_job("one_third",         24'h000001, 24'h000003, Q_THIRD,    1'b0, 1'b0, 0);
    run_job("neg_one_third",     24'hFFFFFF, 24'h000003, Q_NTHIRD,   1'b0, 1'b0, 0);
    run_job("min_over_min",      24'h800000, 24'h800000, 24'h200000, 1'b0, 1'b0, 0);
    run_job("stall_out",         24'hD00000, 24'h100000, 24'hA00000, 1'b0, 1'b0, 10);

    // Abort a job partway through the iterations
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.num      = 24'h200000;
    bus_if.den      = 24'h400000;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    chk("abort in_ready", {31'b0, bus_if.in_ready}, 32'd1);
    chk("abort quot", {8'b0, bus_if.quot}, 32'd0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus_if.out_valid) seen++;
    end
    chk("abort no_result", seen, 0);
    $display("job abort num=0x200000 den=0x400000 reset mid-iteration, result cycles=%0d", seen);

    run_job("after_abort",       24'h200000, 24'h400000, 24'h100000, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
